// File: rtl/sdram_aref.sv
`default_nettype none
// ============================================================================
// Module   : sdram_aref
// Periodic SDRAM auto-refresh sequencer: requests the command bus, then issues
// PRECHARGE ALL followed by AREF_NUM AUTO REFRESH commands.
// Revision : 1.0
// ============================================================================
module sdram_aref #(
    parameter int REF_PERIOD_CYC = 750,
    parameter int TRP_CYC        = 2,
    parameter int TRC_CYC        = 7,
    parameter int AREF_NUM       = 2
) (
    input  logic        aref_clk,
    input  logic        aref_rst_n,
    input  logic        init_end,
    input  logic        ar_en,
    output logic        ar_req,
    output logic        ar_end,
    output logic [3:0]  ar_cmd,
    output logic [1:0]  ar_bank,
    output logic [12:0] ar_addr,
    output logic        ref_overrun
);

    localparam logic [15:0] C_PERIOD_LAST = 16'(REF_PERIOD_CYC - 1);
    localparam logic [7:0]  C_TRP_LOAD    = 8'(TRP_CYC - 1);
    localparam logic [7:0]  C_TRC_LOAD    = 8'(TRC_CYC - 1);
    localparam logic [3:0]  C_AREF_NUM    = 4'(AREF_NUM);
    localparam logic [3:0]  C_CMD_NOP     = 4'b0111;
    localparam logic [3:0]  C_CMD_PCH     = 4'b0010;
    localparam logic [3:0]  C_CMD_REF     = 4'b0001;
    localparam logic [12:0] C_ADDR_IDLE   = 13'h1fff;
    localparam logic [12:0] C_ADDR_PALL   = 13'h0400;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PCH  = 3'd1,
        S_TRP  = 3'd2,
        S_REF  = 3'd3,
        S_TRC  = 3'd4,
        S_END  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_intv_cnt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_nxt;
    logic [3:0]  r_ref_cnt;
    logic [3:0]  w_ref_nxt;
    logic        r_req;
    logic        w_expiry;
    logic        w_start;

    assign w_expiry    = init_end && (r_intv_cnt == C_PERIOD_LAST);
    assign w_start     = (r_state == S_IDLE) && ar_en && r_req;
    assign ar_req      = r_req;
    // A second expiry that finds the previous request unserved is flagged, not queued.
    assign ref_overrun = w_expiry && r_req && !w_start;

    always_ff @(posedge aref_clk or negedge aref_rst_n) begin
        if (!aref_rst_n) begin
            r_intv_cnt <= 16'd0;
        end else if (!init_end || w_expiry) begin
            r_intv_cnt <= 16'd0;
        end else begin
            r_intv_cnt <= r_intv_cnt + 16'd1;
        end
    end

    // Expiry has priority over start so a refresh due on the grant cycle is not lost.
    always_ff @(posedge aref_clk or negedge aref_rst_n) begin
        if (!aref_rst_n) begin
            r_req <= 1'b0;
        end else if (!init_end) begin
            r_req <= 1'b0;
        end else if (w_expiry) begin
            r_req <= 1'b1;
        end else if (w_start) begin
            r_req <= 1'b0;
        end
    end

    always_ff @(posedge aref_clk or negedge aref_rst_n) begin
        if (!aref_rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_ref_cnt  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_ref_cnt  <= w_ref_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_ref_nxt   = r_ref_cnt;
        ar_cmd      = C_CMD_NOP;
        ar_bank     = 2'b11;
        ar_addr     = C_ADDR_IDLE;
        ar_end      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_PCH;
                end
            end
            S_PCH: begin
                ar_cmd      = C_CMD_PCH;
                ar_addr     = C_ADDR_PALL;
                w_wait_nxt  = C_TRP_LOAD;
                w_state_nxt = S_TRP;
            end
            S_TRP: begin
                if (r_wait_cnt == 8'd0) begin
                    w_state_nxt = S_REF;
                end else begin
                    w_wait_nxt = r_wait_cnt - 8'd1;
                end
            end
            S_REF: begin
                ar_cmd      = C_CMD_REF;
                w_ref_nxt   = r_ref_cnt + 4'd1;
                w_wait_nxt  = C_TRC_LOAD;
                w_state_nxt = S_TRC;
            end
            S_TRC: begin
                if (r_wait_cnt != 8'd0) begin
                    w_wait_nxt = r_wait_cnt - 8'd1;
                end else if (r_ref_cnt < C_AREF_NUM) begin
                    w_state_nxt = S_REF;
                end else begin
                    w_state_nxt = S_END;
                end
            end
            S_END: begin
                ar_end      = 1'b1;
                w_ref_nxt   = 4'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_aref.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_aref
// Directed self-checking bench for sdram_aref (default and short-timing builds).
// Revision : 1.0
// ============================================================================
module tb_sdram_aref;

    localparam logic [19:0] C_W_NOP = {1'b0, 4'b0111, 2'b11, 13'h1fff};
    localparam logic [19:0] C_W_PCH = {1'b0, 4'b0010, 2'b11, 13'h0400};
    localparam logic [19:0] C_W_REF = {1'b0, 4'b0001, 2'b11, 13'h1fff};
    localparam logic [19:0] C_W_END = {1'b1, 4'b0111, 2'b11, 13'h1fff};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_end;
    logic        ar_en;
    logic        ar_en2;
    logic        ar_req, ar_end, ref_overrun;
    logic [3:0]  ar_cmd;
    logic [1:0]  ar_bank;
    logic [12:0] ar_addr;
    logic        ar_req2, ar_end2, ref_overrun2;
    logic [3:0]  ar_cmd2;
    logic [1:0]  ar_bank2;
    logic [12:0] ar_addr2;
    logic [19:0] word1, word2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    assign word1 = {ar_end, ar_cmd, ar_bank, ar_addr};
    assign word2 = {ar_end2, ar_cmd2, ar_bank2, ar_addr2};

    always #5 clk = ~clk;

    sdram_aref u_dut (
        .aref_clk    (clk),
        .aref_rst_n  (rst_n),
        .init_end    (init_end),
        .ar_en       (ar_en),
        .ar_req      (ar_req),
        .ar_end      (ar_end),
        .ar_cmd      (ar_cmd),
        .ar_bank     (ar_bank),
        .ar_addr     (ar_addr),
        .ref_overrun (ref_overrun)
    );

    sdram_aref #(
        .REF_PERIOD_CYC (32),
        .TRP_CYC        (1),
        .TRC_CYC        (3),
        .AREF_NUM       (1)
    ) u_dut2 (
        .aref_clk    (clk),
        .aref_rst_n  (rst_n),
        .init_end    (init_end),
        .ar_en       (ar_en2),
        .ar_req      (ar_req2),
        .ar_end      (ar_end2),
        .ar_cmd      (ar_cmd2),
        .ar_bank     (ar_bank2),
        .ar_addr     (ar_addr2),
        .ref_overrun (ref_overrun2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    // First request of a fresh interval: low in cycle 749, high in cycle 750.
    task automatic check_interval(input string tag);
        tick_to(749);
        check_val({tag, "_req749"}, 32'(ar_req), 32'd0);
        tick_to(750);
        check_val({tag, "_req750"}, 32'(ar_req), 32'd1);
    endtask

    function automatic logic [19:0] exp_default(input int j);
        if (j == 1)             return C_W_PCH;
        if (j == 4 || j == 12)  return C_W_REF;
        if (j == 20)            return C_W_END;
        return C_W_NOP;
    endfunction

    function automatic logic [19:0] exp_short(input int j);
        if (j == 1) return C_W_PCH;
        if (j == 3) return C_W_REF;
        if (j == 7) return C_W_END;
        return C_W_NOP;
    endfunction

    initial begin
        int pulses;
        int bad;
        int k;
        rst_n    = 1'b0;
        init_end = 1'b0;
        ar_en    = 1'b0;
        ar_en2   = 1'b0;

        // Reset state
        #12;
        check_val("rst_word", 32'(word1), 32'(C_W_NOP));
        check_val("rst_req", 32'(ar_req), 32'd0);
        check_val("rst_ovr", 32'(ref_overrun), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_val("noinit_req", 32'(ar_req), 32'd0);

        // Interval and overrun with no grants
        init_end = 1'b1;
        cyc = 0;
        check_interval("init");
        tick_to(1498);
        check_val("ovr1498", 32'(ref_overrun), 32'd0);
        tick_to(1499);
        check_val("ovr1499", 32'(ref_overrun), 32'd1);
        tick_to(1500);
        check_val("ovr1500", 32'(ref_overrun), 32'd0);
        pulses = 0;
        bad = 0;
        while (cyc < 2250) begin
            tick();
            if (ref_overrun) pulses++;
            if (!ar_req) bad++;
        end
        check_val("ovr_pulses", 32'(pulses), 32'd1);
        check_val("req_held", 32'(bad), 32'd0);

        // Full default sequence, grant held through the stale cycle
        tick_to(2252);
        check_val("pre_grant_req", 32'(ar_req), 32'd1);
        ar_en = 1'b1;
        bad = 0;
        for (int j = 1; j <= 22; j++) begin
            tick();
            check_val($sformatf("seq_j%0d", j), 32'(word1), 32'(exp_default(j)));
            if (ar_req) bad++;
        end
        check_val("seq_req_low", 32'(bad), 32'd0);
        ar_en = 1'b0;

        // Start coincident with expiry at cycle 3749
        tick_to(3749);
        check_val("coin_pre_req", 32'(ar_req), 32'd1);
        ar_en = 1'b1;
        #1;
        check_val("coin_ovr", 32'(ref_overrun), 32'd0);
        tick();
        ar_en = 1'b0;
        check_val("coin_req", 32'(ar_req), 32'd1);
        check_val("coin_pch", 32'(word1), 32'(C_W_PCH));
        tick_to(3769);
        check_val("coin_end", 32'(word1), 32'(C_W_END));
        tick_to(3770);
        check_val("coin_idle", 32'(word1), 32'(C_W_NOP));
        check_val("coin_req2", 32'(ar_req), 32'd1);
        tick_to(3772);
        ar_en = 1'b1;
        tick();
        ar_en = 1'b0;
        check_val("second_pch", 32'(word1), 32'(C_W_PCH));
        check_val("second_req", 32'(ar_req), 32'd0);

        // Asynchronous reset mid-sequence
        tick_to(4502);
        check_val("rs_pre_req", 32'(ar_req), 32'd1);
        ar_en = 1'b1;
        tick();
        ar_en = 1'b0;
        tick_to(4506);
        check_val("rs_aref", 32'(word1), 32'(C_W_REF));
        tick_to(4508);
        rst_n = 1'b0;
        #1;
        check_val("rs_word", 32'(word1), 32'(C_W_NOP));
        check_val("rs_req", 32'(ar_req), 32'd0);
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (ar_end || ar_req) bad++;
        end
        check_val("rs_quiet", 32'(bad), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        check_interval("rst");

        // init_end drop clears request and freezes the interval
        init_end = 1'b0;
        tick();
        check_val("drop_req", 32'(ar_req), 32'd0);
        bad = 0;
        for (int j = 0; j < 800; j++) begin
            tick();
            if (ar_req || ref_overrun) bad++;
        end
        check_val("drop_frozen", 32'(bad), 32'd0);
        init_end = 1'b1;
        cyc = 0;
        check_interval("reinit");

        // Short-timing build: TRP=1, TRC=3, one refresh
        k = 0;
        while (!ar_req2 && k < 40) begin
            tick();
            k++;
        end
        check_val("short_req", 32'(ar_req2), 32'd1);
        ar_en2 = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            ar_en2 = 1'b0;
            check_val($sformatf("short_j%0d", j), 32'(word2), 32'(exp_short(j)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_aref.md
Name: sdram_aref

Overview:
- Auto-refresh sequencer for the SDRAM controller.
- After initialisation it issues a periodic refresh request to the command arbiter, which owns the SDRAM command bus.
- When granted, it drives one PRECHARGE ALL followed by AREF_NUM AUTO REFRESH commands with tRP/tRC spacing, then signals completion.
- Its outputs feed the arbiter's ar_req/ar_end/ar_cmd/ar_bank/ar_addr inputs, and it takes the arbiter's ar_en grant.

Parameters:
REF_PERIOD_CYC, 750, refresh interval in clocks (7.5 us at 100 MHz); legal range 32..65535
TRP_CYC, 2, NOP cycles after PRECHARGE; legal range 1..255
TRC_CYC, 7, NOP cycles after each AUTO REFRESH; legal range 1..255
AREF_NUM, 2, AUTO REFRESH commands per sequence; legal range 1..8

Ports:
aref_clk  in  1  clock
aref_rst_n  in  1  asynchronous active-low reset
init_end  in  1  SDRAM power-up init complete; level, high once init is done
ar_en  in  1  grant from arbiter; high from grant until the cycle after ar_end
ar_req  out  1  refresh request to arbiter
ar_end  out  1  one-cycle pulse, refresh sequence complete
ar_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
ar_bank  out  2  bank address
ar_addr  out  13  address bus
ref_overrun  out  1  one-cycle pulse, interval expired while a request was still pending

Behaviour:
Fixed by design: one clock, aref_clk; reset aref_rst_n is asynchronous and active-low.

Reset values:
- ar_req=0, ar_end=0, ref_overrun=0.
- ar_cmd=4'b0111 (NOP), ar_bank=2'b11, ar_addr=13'h1fff.
- FSM in IDLE; all counters 0.
- Reset mid-sequence aborts immediately to these values; no completion pulse.

Interval counter (16 bit):
- Held at 0 while init_end=0.
- Otherwise increments each cycle and wraps to 0 after REF_PERIOD_CYC-1 (the "expiry" cycle).
- Free-running; it is never reset by grants.

Request register:
- Set at edge after expiry.
- Cleared at edge when FSM is IDLE and ar_en=1 and ar_req=1 (start).
- Expiry and start in the same cycle: set wins, ar_req stays 1, no overrun.
- Expiry while ar_req=1 and no start: ref_overrun=1 for one cycle; ar_req stays 1, still a single request.
- Expiry while the FSM is busy: sets ar_req normally; it is served at the next grant.
- init_end falling clears ar_req and counter.

FSM:
- Outputs are Moore: decoded from state only, no combinational input paths.
- IDLE: NOP. Goes to PCH when ar_en && ar_req.
- PCH: one cycle, cmd 4'b0010, bank 2'b11, addr 13'h0400 (A10=1, all banks). Goes to TRP.
- TRP: NOP for TRP_CYC cycles. Goes to REF.
- REF: one cycle, cmd 4'b0001. Increments refresh count. Goes to TRC.
- TRC: NOP for TRC_CYC cycles. Goes to REF if refresh count < AREF_NUM, else to END.
- END: one cycle, NOP, ar_end=1. Goes to IDLE and clears refresh count.
- In every non-PCH state: bank 2'b11, addr 13'h1fff.
- A wait counter (8 bit) is loaded on entry to TRP/TRC and the state exits when it reaches terminal count.
- ar_en dropping mid-sequence is ignored; the sequence runs to END.
- ar_en=1 in IDLE without ar_req does not start a sequence. This covers the stale grant in the cycle after END.

Latency:
- Grant seen at cycle k (FSM in IDLE): PCH at k+1.
- First REF at k+2+TRP_CYC.
- ar_end at k+2+TRP_CYC+AREF_NUM*(1+TRC_CYC); that is k+20 with defaults.
- Total command-bus occupancy is 20 cycles with defaults.

Test Plan:
- Reset then init_end=1 at cycle 0, ar_en tied low -> ar_req rises at edge after cycle 749; ref_overrun pulses at cycle 1499, 2249, ...; ar_req stays 1; exactly one pulse per expiry.
- ar_req=1, ar_en rises at cycle k with defaults -> ar_req=0 from k+1. Commands: PCH addr 13'h0400 bank 3 at k+1, NOP k+2..k+3, AREF k+4, NOP k+5..k+11, AREF k+12, NOP k+13..k+19, ar_end=1 only at k+20, IDLE with NOP at k+21. ar_en held high at k+21 causes no restart.
- Parameters TRP_CYC=1, TRC_CYC=3, AREF_NUM=1, grant at k -> PCH k+1, NOP k+2, AREF k+3, NOP k+4..k+6, ar_end k+7.
- Grant timed so start coincides with expiry -> ar_req remains 1 after start, no ref_overrun; a second sequence starts on the next grant after ar_end.
- aref_rst_n pulled low at k+6 mid-sequence -> outputs go asynchronously to NOP/bank 3/addr 1fff with ar_req=0 and no ar_end. After release with init_end=1, the first ar_req rises at edge after cycle 749 of the new count.
- init_end dropped to 0 while ar_req=1 -> ar_req=0 next edge, counter frozen at 0. Re-asserting init_end restarts the full 750-cycle interval.
